// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: instruction-memory fetch handshake between sequencer and memory
interface exec_sequencer_if #(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [WIDTH-1:0]    imem_data;
    modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch/decode/read/exec/writeback instruction sequencer
module exec_sequencer #(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = 8,
    parameter int ALU_LAT  = 1
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iStart,
    input  logic                iStop,
    exec_sequencer_if.master    imem,
    output logic [6:0]          opcode,
    output logic [4:0]          RD,
    output logic [2:0]          Funct3,
    output logic [4:0]          RS1,
    output logic [4:0]          RS2,
    output logic [6:0]          Funct7,
    output logic                rf_rd_en,
    output logic                alu_en,
    output logic                rf_we,
    output logic                oBusy,
    output logic                oHalted,
    output logic                oIllegal,
    output logic [15:0]         oRetired,
    output logic [PC_WIDTH-1:0] pc
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, READ, EXEC, WB, HALT} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    ir_q, ir_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ret_q, ret_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                stop_q, stop_d;
    logic                ill_q, ill_d;
    logic                stop_now;
    logic [6:0]          op;

    assign op = ir_q[6:0];

    // next-state, instruction latch, pc/retire update and stop tracking
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        pc_d     = pc_q;
        ret_d    = ret_q;
        ill_d    = ill_q;
        cnt_d    = '0;
        stop_now = stop_q | (iStop && state_q != IDLE && state_q != HALT);
        stop_d   = stop_now;
        case (state_q)
            IDLE:    state_d = (iStart && !iStop) ? FETCH : IDLE;
            FETCH: begin
                ir_d    = imem.imem_ack ? imem.imem_data : ir_q;
                state_d = imem.imem_ack ? DECODE : FETCH;
            end
            DECODE: begin
                state_d = (op == 7'h33 || op == 7'h13) ? READ : HALT;
                ill_d   = (op == 7'h33 || op == 7'h13) ? ill_q : (op != 7'h73);
            end
            READ:    state_d = EXEC;
            EXEC: begin
                state_d = (cnt_q == 4'(ALU_LAT - 1)) ? WB : EXEC;
                cnt_d   = (cnt_q == 4'(ALU_LAT - 1)) ? 4'd0 : cnt_q + 4'd1;
            end
            WB: begin
                pc_d    = pc_q + PC_WIDTH'(4);
                ret_d   = ret_q + 16'(ret_q != 16'hFFFF);
                state_d = stop_now ? IDLE : FETCH;
            end
            default: ;
        endcase
        if (state_d == IDLE) stop_d = 1'b0;
    end

    // state registers, cleared asynchronously by reset
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            ir_q    <= '0;
            pc_q    <= '0;
            ret_q   <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            ill_q   <= ill_d;
        end
    end

    assign imem.imem_req  = state_q == FETCH;
    assign imem.imem_addr = pc_q;
    assign opcode         = ir_q[6:0];
    assign RD             = ir_q[11:7];
    assign Funct3         = ir_q[14:12];
    assign RS1            = ir_q[19:15];
    assign RS2            = ir_q[24:20];
    assign Funct7         = ir_q[31:25];
    assign rf_rd_en       = state_q == READ;
    assign alu_en         = state_q == EXEC;
    assign rf_we          = state_q == WB && ir_q[11:7] != 5'd0;
    assign oBusy          = state_q != IDLE && state_q != HALT;
    assign oHalted        = state_q == HALT;
    assign oIllegal       = state_q == HALT && ill_q;
    assign oRetired       = ret_q;
    assign pc             = pc_q;
endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: instruction word width in bits.
REQ-002 Parameter PC_WIDTH, default 8: byte-address width of the program counter.
REQ-003 Parameter ALU_LAT, default 1: cycles alu_en is held per instruction, range 1..15.
REQ-004 iClk  in  1  the single clock; all state changes on the rising edge.
REQ-005 iRstN  in  1  reset, asynchronous assert and active-low; release is synchronous to iClk.
REQ-006 iStart  in  1  begin execution from the current PC; sampled in IDLE only.
REQ-007 iStop  in  1  request to stop after the current instruction retires.
REQ-008 imem_req  out  1  fetch request, held high until acknowledged.
REQ-009 imem_addr  out  PC_WIDTH  fetch byte address; equals pc.
REQ-010 imem_ack  in  1  fetch acknowledge; imem_data is valid in the same cycle.
REQ-011 imem_data  in  WIDTH  fetched instruction word.
REQ-012 opcode, RD, Funct3, RS1, RS2, Funct7  out  7, 5, 3, 5, 5, 7  registered decode fields (bits 6:0, 11:7, 14:12, 19:15, 24:20, 31:25).
REQ-013 rf_rd_en  out  1  register-file read strobe.
REQ-014 alu_en  out  1  ALU execute enable.
REQ-015 rf_we  out  1  register-file write strobe for RD.
REQ-016 oBusy  out  1  high in every state except IDLE and HALT.
REQ-017 oHalted  out  1  high in HALT.
REQ-018 oIllegal  out  1  high in HALT when the halt was caused by an illegal opcode.
REQ-019 oRetired  out  16  count of retired instructions.
REQ-020 pc  out  PC_WIDTH  current program counter.

Function
REQ-021 The FSM states are IDLE, FETCH, DECODE, READ, EXEC, WB and HALT, with one state per cycle unless a rule below stalls it.
REQ-022 IDLE: when iStart=1 and iStop=0, the next state is FETCH; when iStart and iStop are both 1, the block stays in IDLE.
REQ-023 FETCH: imem_req=1 and imem_addr=pc; on the cycle imem_ack=1, the block latches imem_data into the instruction register and goes to DECODE; with no ack it stalls indefinitely.
REQ-024 An imem_ack outside FETCH is ignored.
REQ-025 DECODE: decode fields become valid and stay stable until the next DECODE.
REQ-026 DECODE: opcode 0110011 (R-type) or 0010011 (I-type) goes to READ.
REQ-027 DECODE: opcode 1110011 (ECALL) goes to HALT with oIllegal=0.
REQ-028 DECODE: any other opcode goes to HALT with oIllegal=1.
REQ-029 READ: rf_rd_en=1 for exactly one cycle, then EXEC.
REQ-030 EXEC: alu_en=1 for exactly ALU_LAT consecutive cycles, timed by an internal counter, then WB.
REQ-031 WB: one cycle.
REQ-032 WB: rf_we=1 only when RD!=0; RD=0 suppresses the write but the instruction still retires.
REQ-033 WB: pc advances by 4, wrapping modulo 2^PC_WIDTH.
REQ-034 WB: oRetired increments by 1 and saturates at 0xFFFF.
REQ-035 WB: the next state is IDLE if a stop is pending, otherwise FETCH.
REQ-036 The stop-pending flag sets when iStop=1 in FETCH, DECODE, READ, EXEC or WB, and clears on entry to IDLE.
REQ-037 A stop raised in WB itself takes effect in that same WB.
REQ-038 A stop never aborts an instruction already fetched.
REQ-039 HALT is terminal: only reset leaves it; iStart and iStop are ignored there; rf_we, alu_en, rf_rd_en and imem_req are 0.
REQ-040 At most one of imem_req, rf_rd_en, alu_en and rf_we is high in any cycle.
REQ-041 An instruction fetched at PC 0xFC with PC_WIDTH=8 retires with pc wrapping to 0x00.

Reset
REQ-042 While iRstN=0, all outputs are 0 and the FSM is in IDLE: pc=0, oRetired=0, decode fields 0, stop-pending=0, ALU_LAT counter=0.
REQ-043 Reset asserted mid-instruction, including during a FETCH stall, discards the instruction with no rf_we pulse.

Verification
REQ-044 Scenario 1: reset, iStart pulse, imem returns 0x002081B3 (add x3,x1,x2) with 0-cycle ack wait, then iStop -> rf_rd_en at cycle 3, alu_en at cycle 4, rf_we at cycle 5, oRetired=1, pc=4, IDLE.
REQ-045 Scenario 2: ALU_LAT=3, imem ack delayed 5 cycles -> imem_req held 6 cycles with imem_addr stable, alu_en high exactly 3 cycles, one rf_we.
REQ-046 Scenario 3: instruction 0x00000033 (RD=0) -> no rf_we pulse, oRetired increments, pc+4.
REQ-047 Scenario 4: instruction 0x0000007F -> HALT, oHalted=1, oIllegal=1, oBusy=0; later iStart gives no imem_req; ECALL 0x00000073 -> oHalted=1, oIllegal=0.
REQ-048 Scenario 5: PC_WIDTH=8, 64 sequential R-type instructions from pc=0 -> after the 64th WB, pc=0x00 and oRetired=64.
REQ-049 Scenario 6: iRstN low during EXEC -> outputs 0 asynchronously, no rf_we, and iStart after release fetches from address 0.
